// File: rtl/mem_access_wb.sv
// Memory-access stage + MEM/WB register: req/ack data-memory handshake, stalls upstream while busy.
// Latency: 1 cycle for non-memory ops, 2+N for memory ops; stall_o is combinational and bounded by WAIT_LIMIT.
module mem_access_wb #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MEMR_i,
  input  logic        MEMW_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] ALUout_i,
  input  logic [31:0] RS2_i,
  input  logic [4:0]  RDaddr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        err_o,
  output logic [1:0]  WB_o,
  output logic [31:0] MEMdata_o,
  output logic [31:0] ALUout_o,
  output logic [4:0]  RDaddr_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [1:0]  wb_q, wb_d;
  logic [31:0] memdata_q, memdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        mem_op;
  logic        timeout;
  logic        stall;

  assign mem_op  = MEMR_i | MEMW_i;
  // Ack wins over timeout when both land in the last allowed cycle.
  assign timeout = (state_q == BUSY) && !dmem_ack_i && (cnt_q == 8'(WAIT_LIMIT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    wb_d      = wb_q;
    memdata_d = memdata_q;
    alu_d     = alu_q;
    rd_d      = rd_q;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          wb_d    = 2'b00;
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = MEMW_i;
          addr_d  = ALUout_i;
          wdata_d = RS2_i;
          cnt_d   = 8'd0;
        end else begin
          wb_d      = WB_i;
          alu_d     = ALUout_i;
          rd_d      = RDaddr_i;
          memdata_d = 32'd0;
        end
      end
      BUSY: begin
        if (dmem_ack_i) begin
          wb_d      = WB_i;
          alu_d     = ALUout_i;
          rd_d      = RDaddr_i;
          memdata_d = we_q ? 32'd0 : dmem_rdata_i;
          req_d     = 1'b0;
          state_d   = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          wb_d    = 2'b00;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          wb_d  = 2'b00;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      wb_q      <= 2'b00;
      memdata_q <= 32'd0;
      alu_q     <= 32'd0;
      rd_q      <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      wb_q      <= wb_d;
      memdata_q <= memdata_d;
      alu_q     <= alu_d;
      rd_q      <= rd_d;
    end
  end

  // Gate with reset so a held memory op in EX/MEM cannot keep stalling during reset.
  assign stall_o      = stall & rst_i;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign err_o        = err_q;
  assign WB_o         = wb_q;
  assign MEMdata_o    = memdata_q;
  assign ALUout_o     = alu_q;
  assign RDaddr_o     = rd_q;

endmodule

// File: tb/tb_mem_access_wb.sv
// Bench for mem_access_wb: directed and random ops against a transaction-level model of the MEM/WB result.
module tb_mem_access_wb;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MEMR_i = 1'b0, MEMW_i = 1'b0;
  logic [1:0]  WB_i = 2'b00;
  logic [31:0] ALUout_i = '0, RS2_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        stall_o, err_o;
  logic [1:0]  WB_o;
  logic [31:0] MEMdata_o, ALUout_o;
  logic [4:0]  RDaddr_o;

  int errors = 0;
  int checks = 0;

  // Model of the architectural MEM/WB contents and sticky error flag
  logic [1:0]  m_wb = '0;
  logic [31:0] m_alu = '0, m_data = '0;
  logic [4:0]  m_rd = '0;
  logic        m_err = 1'b0;

  mem_access_wb #(.WAIT_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .MEMR_i(MEMR_i), .MEMW_i(MEMW_i), .WB_i(WB_i),
    .ALUout_i(ALUout_i), .RS2_i(RS2_i), .RDaddr_i(RDaddr_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .err_o(err_o), .WB_o(WB_o),
    .MEMdata_o(MEMdata_o), .ALUout_o(ALUout_o), .RDaddr_o(RDaddr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  // One instruction from EX/MEM until the stage releases it; ack_at = BUSY cycle of the ack, 0 or >LIMIT = never.
  // Must be called at a negedge; returns at a negedge.
  task automatic run_op(input logic r, input logic w, input logic [1:0] wb, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic [4:0] rd, input int ack_at, input logic [31:0] rdata);
    int n_stall, n_req, cyc, exp_cyc;
    bit done, mem_op, acked;
    mem_op = r | w;
    acked  = mem_op && ack_at >= 1 && ack_at <= LIMIT;
    exp_cyc = !mem_op ? 0 : (acked ? ack_at : LIMIT);
    MEMR_i = r; MEMW_i = w; WB_i = wb; ALUout_i = alu; RS2_i = rs2; RDaddr_i = rd;
    n_stall = 0; n_req = 0; cyc = 0; done = 0;
    while (!done && cyc < LIMIT + 4) begin
      if (dmem_req_o === 1'b1) begin
        n_req++;
        checks++; if (dmem_we_o !== w) begin errors++; $display("FAIL req_we: got %b want %b", dmem_we_o, w); end
        checks++; if (dmem_addr_o !== alu) begin errors++; $display("FAIL req_addr: got %h want %h", dmem_addr_o, alu); end
        if (w) begin
          checks++; if (dmem_wdata_o !== rs2) begin errors++; $display("FAIL req_wdata: got %h want %h", dmem_wdata_o, rs2); end
        end
      end
      if (cyc > 0) begin
        checks++; if (WB_o !== 2'b00) begin errors++; $display("FAIL bubble_wb: got %b want 00", WB_o); end
      end
      if (mem_op) dmem_ack_i = (dmem_req_o === 1'b1) && (n_req == ack_at);
      else dmem_ack_i = 1'($urandom_range(0, 1));
      dmem_rdata_i = dmem_ack_i ? rdata : $urandom;
      #1;
      if (stall_o === 1'b1) n_stall++; else done = 1;
      cyc++;
      @(negedge clk);
    end
    dmem_ack_i = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL release_bound: got stalled want released within %0d", LIMIT + 4); end
    checks++; if (n_stall != exp_cyc) begin errors++; $display("FAIL stall_cycles: got %0d want %0d", n_stall, exp_cyc); end
    checks++; if (n_req != exp_cyc) begin errors++; $display("FAIL req_cycles: got %0d want %0d", n_req, exp_cyc); end
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL req_after: got %b want 0", dmem_req_o); end
    if (!mem_op || acked) begin
      m_wb = wb; m_alu = alu; m_rd = rd;
      m_data = (mem_op && !w) ? rdata : 32'd0;
    end else begin
      m_wb = 2'b00; m_err = 1'b1;
    end
    checks++; if (WB_o !== m_wb) begin errors++; $display("FAIL wb_out: got %b want %b", WB_o, m_wb); end
    checks++; if (ALUout_o !== m_alu) begin errors++; $display("FAIL alu_out: got %h want %h", ALUout_o, m_alu); end
    checks++; if (RDaddr_o !== m_rd) begin errors++; $display("FAIL rd_out: got %0d want %0d", RDaddr_o, m_rd); end
    checks++; if (MEMdata_o !== m_data) begin errors++; $display("FAIL memdata_out: got %h want %h", MEMdata_o, m_data); end
    checks++; if (err_o !== m_err) begin errors++; $display("FAIL err_out: got %b want %b", err_o, m_err); end
  endtask

  task automatic check_all_zero(input string tag);
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL %s_req: got %b want 0", tag, dmem_req_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL %s_stall: got %b want 0", tag, stall_o); end
    checks++; if ({dmem_we_o, dmem_addr_o, dmem_wdata_o} !== 65'd0) begin errors++; $display("FAIL %s_reqfields: got %b/%h/%h want 0", tag, dmem_we_o, dmem_addr_o, dmem_wdata_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL %s_err: got %b want 0", tag, err_o); end
    checks++; if ({WB_o, RDaddr_o} !== 7'd0) begin errors++; $display("FAIL %s_wb_rd: got %b/%0d want 0", tag, WB_o, RDaddr_o); end
    checks++; if ({MEMdata_o, ALUout_o} !== 64'd0) begin errors++; $display("FAIL %s_data: got %h/%h want 0", tag, MEMdata_o, ALUout_o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    MEMR_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    MEMR_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    run_op(1'b0, 1'b0, 2'b10, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
  endtask

  task automatic test_load();
    run_op(1'b1, 1'b0, 2'b11, 32'h100, 32'h5555, 5'd9, 3, 32'hDEADBEEF);
  endtask

  task automatic test_store();
    run_op(1'b0, 1'b1, 2'b00, 32'h40, 32'hA5A5A5A5, 5'd0, 1, 32'h13572468);
  endtask

  task automatic test_timeout();
    run_op(1'b1, 1'b0, 2'b11, 32'h200, 32'h0, 5'd7, 0, 32'h0);
    run_op(1'b0, 1'b0, 2'b10, 32'h77, 32'h0, 5'd3, 0, 32'h0);
    run_op(1'b1, 1'b0, 2'b11, 32'h204, 32'h0, 5'd8, LIMIT, 32'h600DF00D);
  endtask

  task automatic test_both();
    run_op(1'b1, 1'b1, 2'b10, 32'h80, 32'hFEEDFACE, 5'd12, 2, 32'hBAD0BAD0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 3);
      run_op(k[0], k[1], 2'($urandom), $urandom, $urandom, 5'($urandom),
             $urandom_range(0, LIMIT + 1), $urandom);
    end
  endtask

  task automatic test_reset_mid();
    MEMR_i = 1'b1; MEMW_i = 1'b0; WB_i = 2'b11; ALUout_i = 32'h300; RDaddr_i = 5'd4;
    dmem_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL mid_req_before: got %b want 1", dmem_req_o); end
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    m_wb = '0; m_alu = '0; m_data = '0; m_rd = '0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL late_ack_stall: got %b want 1", stall_o); end
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL late_ack_req: got %b want 1", dmem_req_o); end
    checks++; if ({WB_o, MEMdata_o} !== 34'd0) begin errors++; $display("FAIL late_ack_wb: got %b/%h want 0", WB_o, MEMdata_o); end
    dmem_rdata_i = 32'h0BADC0DE;
    @(negedge clk);
    dmem_ack_i = 1'b0;
    checks++; if (MEMdata_o !== 32'h0BADC0DE) begin errors++; $display("FAIL post_reset_load: got %h want 0badc0de", MEMdata_o); end
    checks++; if (WB_o !== 2'b11 || RDaddr_o !== 5'd4) begin errors++; $display("FAIL post_reset_wb: got %b/%0d want 11/4", WB_o, RDaddr_o); end
    m_wb = 2'b11; m_alu = 32'h300; m_rd = 5'd4; m_data = 32'h0BADC0DE;
    run_op(1'b0, 1'b0, 2'b10, 32'h4321, 32'h0, 5'd6, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_both();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
